// File: rtl/axi_burst_rd_pkg.sv
// Shared types, constants and burst-sizing helper for the AXI burst read streamer.
package axi_burst_rd_pkg;

  localparam int unsigned PageBits  = 12;
  localparam int unsigned PageBytes = 1 << PageBits;
  localparam logic [1:0]  BurstIncr = 2'b01;

  // Default AXI4 channel widths used by the default req_t/rsp_t types.
  localparam int unsigned AxiAddrW = 32;
  localparam int unsigned AxiDataW = 64;
  localparam int unsigned AxiIdW   = 4;
  localparam int unsigned AxiUserW = 1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic                lock;
    logic [3:0]          cache;
    logic [2:0]          prot;
    logic [3:0]          qos;
    logic [3:0]          region;
    logic [AxiUserW-1:0] user;
  } axi_ax_chan_t;

  typedef struct packed {
    logic [AxiDataW-1:0]   data;
    logic [AxiDataW/8-1:0] strb;
    logic                  last;
    logic [AxiUserW-1:0]   user;
  } axi_w_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [1:0]          resp;
    logic [AxiUserW-1:0] user;
  } axi_b_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiDataW-1:0] data;
    logic [1:0]          resp;
    logic                last;
    logic [AxiUserW-1:0] user;
  } axi_r_chan_t;

  typedef struct packed {
    axi_ax_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_rsp_t;

  // Beats in the next burst: limited by remaining beats, max burst length
  // and the distance to the next 4 KiB page boundary.
  function automatic int unsigned calc_burst_beats(
    input logic [PageBits-1:0] addr,
    input int unsigned         rem,
    input int unsigned         max_len,
    input int unsigned         strb_width
  );
    int unsigned n;
    int unsigned page_beats;
    page_beats = (PageBytes - 32'(addr)) / strb_width;
    n = rem;
    if (n > max_len)    n = max_len;
    if (n > page_beats) n = page_beats;
    return n;
  endfunction

endpackage

// File: rtl/axi_burst_rd_streamer_fifo.sv
// Small synchronous FIFO holding per-burst beat counts for the R-last check.
module axi_burst_rd_streamer_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (32'(cnt_q) == Depth);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage write, no reset needed on the data array.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= (32'(wr_ptr_q) == Depth - 1) ? '0 : wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= (32'(rd_ptr_q) == Depth - 1) ? '0 : rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

endmodule

// File: rtl/axi_burst_rd_streamer.sv
// AXI4 read master: splits a linear read command into INCR bursts and streams R data.
module axi_burst_rd_streamer
  import axi_burst_rd_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned UserWidth   = 1,
  parameter int unsigned ArId        = 0,
  parameter int unsigned MaxBurstLen = 16,
  parameter int unsigned MaxTxns     = 4,
  parameter int unsigned CntWidth    = 16,
  parameter type         req_t       = axi_req_t,
  parameter type         rsp_t       = axi_rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [CntWidth-1:0]  cmd_beats_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_last_o,
  output logic                 out_err_o,
  output logic                 busy_o,
  output req_t                 axi_req_o,
  input  rsp_t                 axi_rsp_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned SizeLog   = $clog2(StrbWidth);
  localparam int unsigned OutW      = $clog2(MaxTxns + 1);

  state_e               state_q;
  logic                 cmd_ready_q, ar_valid_q;
  logic [AddrWidth-1:0] next_addr_q, addr_nxt;
  logic [7:0]           ar_len_q;
  logic [CntWidth-1:0]  issue_rem_q, recv_rem_q, rem_nxt;
  logic [OutW-1:0]      outst_q, outst_nxt;
  logic [8:0]           cur_beats, burst_nxt, burst_cmd;
  logic                 ar_hs, r_hs, r_last_hs;
  logic [8:0]           fifo_head, beat_cnt_q;
  logic                 fifo_empty, fifo_full;
  logic                 unused_rsp;

  // Handshakes and the address/remaining-count state after this cycle's AR.
  always_comb begin
    cur_beats = {1'b0, ar_len_q} + 9'd1;
    ar_hs     = ar_valid_q && axi_rsp_i.ar_ready;
    r_hs      = axi_rsp_i.r_valid && out_ready_i;
    r_last_hs = r_hs && axi_rsp_i.r.last;
    addr_nxt  = next_addr_q;
    rem_nxt   = issue_rem_q;
    if (ar_hs) begin
      addr_nxt = next_addr_q + (AddrWidth'(cur_beats) << SizeLog);
      rem_nxt  = issue_rem_q - CntWidth'(cur_beats);
    end
    outst_nxt = outst_q + OutW'(ar_hs) - OutW'(r_last_hs);
    burst_nxt = 9'(calc_burst_beats(addr_nxt[PageBits-1:0], 32'(rem_nxt),
                                    MaxBurstLen, StrbWidth));
    burst_cmd = 9'(calc_burst_beats(cmd_addr_i[PageBits-1:0], 32'(cmd_beats_i),
                                    MaxBurstLen, StrbWidth));
  end

  // AXI request: AR from registers, R ready straight from the consumer, rest tied off.
  always_comb begin
    axi_req_o          = '0;
    axi_req_o.ar_valid = ar_valid_q;
    axi_req_o.ar.addr  = next_addr_q;
    axi_req_o.ar.len   = ar_len_q;
    axi_req_o.ar.size  = 3'(SizeLog);
    axi_req_o.ar.burst = BurstIncr;
    axi_req_o.ar.id    = IdWidth'(ArId);
    axi_req_o.r_ready  = out_ready_i;
  end

  assign cmd_ready_o = cmd_ready_q;
  assign out_valid_o = axi_rsp_i.r_valid;
  assign out_data_o  = axi_rsp_i.r.data;
  assign out_err_o   = axi_rsp_i.r.resp[1];
  assign out_last_o  = axi_rsp_i.r_valid && (recv_rem_q == CntWidth'(1));
  assign busy_o      = (state_q != StIdle);
  assign unused_rsp  = ^axi_rsp_i;

  // Command FSM with registered AR; the next burst is preloaded on the
  // AR handshake edge so back-to-back bursts need no idle cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      ar_valid_q  <= 1'b0;
      next_addr_q <= '0;
      ar_len_q    <= '0;
      issue_rem_q <= '0;
      recv_rem_q  <= '0;
      outst_q     <= '0;
    end else begin
      outst_q <= outst_nxt;
      if (r_hs) recv_rem_q <= recv_rem_q - CntWidth'(1);
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i && cmd_ready_q) begin
            next_addr_q <= cmd_addr_i;
            issue_rem_q <= cmd_beats_i;
            recv_rem_q  <= cmd_beats_i;
            ar_valid_q  <= (cmd_beats_i != '0);
            ar_len_q    <= 8'(burst_cmd - 9'd1);
            cmd_ready_q <= 1'b0;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          next_addr_q <= addr_nxt;
          issue_rem_q <= rem_nxt;
          if (rem_nxt == '0) begin
            ar_valid_q <= 1'b0;
            state_q    <= StDrain;
          end else if (!ar_valid_q || ar_hs) begin
            ar_valid_q <= (32'(outst_nxt) < MaxTxns);
            ar_len_q   <= 8'(burst_nxt - 9'd1);
          end
        end
        StDrain: begin
          if (recv_rem_q == '0 && outst_q == '0) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  axi_burst_rd_streamer_fifo #(
    .Depth (MaxTxns),
    .Width (9)
  ) i_len_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ar_hs),
    .data_i  (cur_beats),
    .pop_i   (r_last_hs),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Beat position within the burst currently returning on R.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt_q <= '0;
    end else if (r_hs) begin
      beat_cnt_q <= axi_rsp_i.r.last ? '0 : beat_cnt_q + 9'd1;
    end
  end

  a_r_id: assert property (@(posedge clk_i) disable iff (rst_i)
    r_hs |-> axi_rsp_i.r.id == IdWidth'(ArId));
  a_r_expected: assert property (@(posedge clk_i) disable iff (rst_i)
    r_hs |-> !fifo_empty);
  a_r_last: assert property (@(posedge clk_i) disable iff (rst_i)
    r_hs |-> (axi_rsp_i.r.last == (beat_cnt_q + 9'd1 == fifo_head)));
  a_ar_room: assert property (@(posedge clk_i) disable iff (rst_i)
    ar_hs |-> !fifo_full);
  a_cmd_ok: assert property (@(posedge clk_i) disable iff (rst_i)
    (cmd_valid_i && cmd_ready_o) |->
      (cmd_beats_i != '0) && ((cmd_addr_i % AddrWidth'(StrbWidth)) == '0));

endmodule

// File: tb/tb_axi_burst_rd_streamer.sv
// Self-checking bench: randomized AXI slave plus a command-level reference model.
module tb_axi_burst_rd_streamer;
  import axi_burst_rd_pkg::*;

  localparam int unsigned Txns = 2;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic        out_valid, out_ready, out_last, out_err, busy;
  logic [63:0] out_data;
  axi_req_t    req;
  axi_rsp_t    rsp;

  axi_burst_rd_streamer #(
    .MaxBurstLen (16),
    .MaxTxns     (Txns)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_addr_i  (cmd_addr),
    .cmd_beats_i (cmd_beats),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .out_err_o   (out_err),
    .busy_o      (busy),
    .axi_req_o   (req),
    .axi_rsp_i   (rsp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [31:0] addr; logic last; int t; } rbeat_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; logic [2:0] size;
                   logic [1:0] burst; logic [3:0] id; } arobs_t;
  typedef struct { logic [63:0] data; logic last; logic err; } beat_t;

  rbeat_t  rq[$];
  arobs_t  ar_obs[$];
  beat_t   beat_obs[$];

  int          checks = 0, errors = 0;
  int          p_ar = 100, p_r = 100, p_out = 100, r_delay = 0;
  int          cur_out = 0, max_out = 0, cyc = 0;
  logic [31:0] err_addr = '1;
  logic        rv = 1'b0;

  function automatic logic [63:0] data_of(input logic [31:0] a);
    return {~a, a ^ 32'h5A5A_0000};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // AXI slave model and output monitor: handshakes sampled on the falling edge,
  // new slave outputs driven just after the rising edge.
  initial begin
    rsp = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        rq.delete();
        rv = 1'b0;
        cur_out = 0;
      end else begin
        if (req.ar_valid && rsp.ar_ready) begin
          ar_obs.push_back('{req.ar.addr, req.ar.len, req.ar.size, req.ar.burst, req.ar.id});
          for (int k = 0; k <= int'(req.ar.len); k++)
            rq.push_back('{req.ar.addr + 32'(k * 8), (k == int'(req.ar.len)), cyc + r_delay});
          cur_out++;
        end
        if (out_valid && out_ready)
          beat_obs.push_back('{out_data, out_last, out_err});
        if (rsp.r_valid && req.r_ready) begin
          if (rsp.r.last) cur_out--;
          if (rq.size() > 0) void'(rq.pop_front());
          rv = 1'b0;
        end
        if (cur_out > max_out) max_out = cur_out;
      end
      @(posedge clk);
      #1;
      rsp.ar_ready = ($urandom_range(99) < p_ar);
      out_ready    = ($urandom_range(99) < p_out);
      if (!rv && rq.size() > 0 && cyc >= rq[0].t && $urandom_range(99) < p_r) rv = 1'b1;
      rsp.r_valid = rv;
      if (rv) begin
        rsp.r.data = data_of(rq[0].addr);
        rsp.r.last = rq[0].last;
        rsp.r.resp = (rq[0].addr == err_addr) ? 2'b10 : 2'b00;
        rsp.r.id   = '0;
      end else begin
        rsp.r = '0;
      end
    end
  end

  task automatic send_cmd(input logic [31:0] a, input int beats, output bit accepted);
    int n;
    ar_obs.delete();
    beat_obs.delete();
    max_out = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_beats = 16'(beats);
    accepted  = 1'b0;
    n = 0;
    while (!accepted && n < 200) begin
      @(negedge clk);
      accepted = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", 64'(accepted), 64'd1);
  endtask

  // Wait for completion, then compare ARs and output beats to the reference.
  task automatic run_cmd(input logic [31:0] a, input int beats);
    bit          accepted, done;
    int          n, nb, rem;
    logic [31:0] pa;
    arobs_t      exp_ar[$];
    send_cmd(a, beats, accepted);
    done = 1'b0;
    n = 0;
    while (accepted && !done && n < 20000) begin
      @(negedge clk);
      done = (beat_obs.size() >= beats) && !busy;
      n++;
    end
    check("cmd_done", 64'(done), 64'd1);
    pa = a;
    rem = beats;
    while (rem > 0) begin
      nb = rem;
      if (nb > 16) nb = 16;
      if (nb > (4096 - int'(pa % 4096)) / 8) nb = (4096 - int'(pa % 4096)) / 8;
      exp_ar.push_back('{pa, 8'(nb - 1), 3'd3, 2'b01, 4'd0});
      pa += 32'(nb * 8);
      rem -= nb;
    end
    check("ar_count", 64'(ar_obs.size()), 64'(exp_ar.size()));
    for (int i = 0; i < exp_ar.size() && i < ar_obs.size(); i++) begin
      check("ar_addr",  64'(ar_obs[i].addr),  64'(exp_ar[i].addr));
      check("ar_len",   64'(ar_obs[i].len),   64'(exp_ar[i].len));
      check("ar_size",  64'(ar_obs[i].size),  64'(exp_ar[i].size));
      check("ar_burst", 64'(ar_obs[i].burst), 64'(exp_ar[i].burst));
      check("ar_id",    64'(ar_obs[i].id),    64'(exp_ar[i].id));
    end
    check("beat_count", 64'(beat_obs.size()), 64'(beats));
    for (int i = 0; i < beats && i < beat_obs.size(); i++) begin
      check("out_data", beat_obs[i].data, data_of(a + 32'(i * 8)));
      check("out_last", 64'(beat_obs[i].last), 64'(i == beats - 1));
      check("out_err",  64'(beat_obs[i].err),  64'((a + 32'(i * 8)) == err_addr));
    end
    check("max_outst_le", 64'(max_out <= int'(Txns)), 64'd1);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    bit          acc;
    logic [31:0] a;
    int          beats;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_beats = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ar_valid", 64'(req.ar_valid), 64'd0);

    run_cmd(32'h1000, 4);
    run_cmd(32'h0FF0, 4);
    run_cmd(32'h0000, 40);

    r_delay = 20;
    run_cmd(32'h2000, 64);
    check("max_outst_reached", 64'(max_out), 64'(Txns));
    r_delay = 0;

    err_addr = 32'h3008;
    run_cmd(32'h3000, 3);
    err_addr = '1;

    for (int it = 0; it < 8; it++) begin
      p_ar  = $urandom_range(30, 100);
      p_r   = $urandom_range(30, 100);
      p_out = $urandom_range(30, 100);
      r_delay = $urandom_range(0, 5);
      if ($urandom_range(1) == 1)
        a = 32'($urandom_range(0, 15) * 4096 + 4096 - $urandom_range(1, 40) * 8);
      else
        a = 32'($urandom_range(0, 15) * 4096 + $urandom_range(0, 511) * 8);
      beats = $urandom_range(1, 60);
      err_addr = ($urandom_range(1) == 1) ? a + 32'($urandom_range(0, beats - 1) * 8) : '1;
      run_cmd(a, beats);
    end
    p_ar = 100; p_r = 100; p_out = 100; err_addr = '1;

    r_delay = 3;
    send_cmd(32'h4000, 40, acc);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_ar_valid", 64'(req.ar_valid), 64'd0);
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    r_delay = 0;
    run_cmd(32'h5000, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
